// File: rtl/ace_snoop_pkg.sv
// Shared encodings for the ACE snoop initiator: AC opcodes, FSM states and
// register-field positions used by the RTL and its bench.
package ace_snoop_pkg;

  localparam logic [3:0] ACSNOOP_READ_ONCE       = 4'b0000;
  localparam logic [3:0] ACSNOOP_READ_SHARED     = 4'b0001;
  localparam logic [3:0] ACSNOOP_READ_CLEAN      = 4'b0010;
  localparam logic [3:0] ACSNOOP_READ_UNIQUE     = 4'b0111;
  localparam logic [3:0] ACSNOOP_CLEAN_INVALID   = 4'b1001;
  localparam logic [3:0] ACSNOOP_MAKE_INVALID    = 4'b1101;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_AC_REQ  = 4'd1,
    ST_CR_WAIT = 4'd2,
    ST_CD_RECV = 4'd3,
    ST_DONE    = 4'd4,
    ST_TIMEOUT = 4'd5
  } state_e;

  localparam int CTRL_START     = 0;
  localparam int CTRL_SNOOP_LSB = 1;
  localparam int CTRL_PROT_LSB  = 5;
  localparam int CTRL_CLEAR     = 8;

  localparam int STAT_DONE       = 0;
  localparam int STAT_TIMEOUT    = 1;
  localparam int STAT_PASS_DIRTY = 2;
  localparam int STAT_CD_ERROR   = 3;
  localparam int STAT_CRRESP_LSB = 4;
  localparam int STAT_STATE_LSB  = 12;

  localparam int CRRESP_DATA_XFER  = 0;
  localparam int CRRESP_PASS_DIRTY = 2;

endpackage

// File: rtl/ace_cd_line_buffer.sv
// Collects CD beats into one cache line and flags short or over-long bursts.
module ace_cd_line_buffer
  import ace_snoop_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      err_clear,
  input  logic                      beat_wr,
  input  logic                      beat_last,
  input  logic [DATA_W-1:0]         beat_data,
  output logic [DATA_W*BEATS-1:0]   line_data,
  output logic                      cd_error
);

  localparam int BW = $clog2(BEATS + 1);
  localparam logic [BW-1:0] BEAT_FULL = BW'(BEATS);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  logic [BW-1:0] beat;

  // beat parks at BEAT_FULL so any extra beat keeps reporting an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      line_data <= '0;
      cd_error  <= 1'b0;
    end else if (clear) begin
      beat      <= '0;
      line_data <= '0;
      cd_error  <= 1'b0;
    end else begin
      if (err_clear)
        cd_error <= 1'b0;
      if (beat_wr) begin
        for (int b = 0; b < BEATS; b++)
          if (beat == BW'(b))
            line_data[b*DATA_W +: DATA_W] <= beat_data;
        if (beat != BEAT_FULL)
          beat <= beat + 1'b1;
        if (beat == BEAT_FULL || (beat_last && beat != BEAT_LAST))
          cd_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ace_snoop_initiator.sv
// Issues one ACE snoop per start edge, collects CR/CD and reports latency.
// state      | meaning
// IDLE       | waiting for a start edge; clear honoured here
// AC_REQ     | acvalid held with stable address/opcode until acready
// CR_WAIT    | crready high, latency counter running
// CD_RECV    | cdready high, beats captured until cdlast
// DONE       | one cycle: set done, return to IDLE
// TIMEOUT    | one cycle: set done and timeout, return to IDLE
module ace_snoop_initiator
  import ace_snoop_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_ACE_DATA_WIDTH   = 128,
  parameter int C_ACE_ADDR_WIDTH   = 44,
  parameter int C_CD_BEATS         = 4
) (
  input  logic                                   ace_aclk,
  input  logic                                   ace_aresetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_control_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_timeout_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          o_status_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          o_latency_reg,
  output logic [C_ACE_DATA_WIDTH*C_CD_BEATS-1:0] o_line_data,
  output logic                                   o_acvalid,
  input  logic                                   i_acready,
  output logic [C_ACE_ADDR_WIDTH-1:0]            o_acaddr,
  output logic [3:0]                             o_acsnoop,
  output logic [2:0]                             o_acprot,
  input  logic                                   i_crvalid,
  input  logic [4:0]                             i_crresp,
  output logic                                   o_crready,
  input  logic                                   i_cdvalid,
  input  logic [C_ACE_DATA_WIDTH-1:0]            i_cddata,
  input  logic                                   i_cdlast,
  output logic                                   o_cdready,
  output logic                                   o_busy
);

  state_e                          state;
  logic                            start_q, done_q, timeout_q, pass_dirty_q;
  logic [4:0]                      crresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   cnt, cnt_inc;
  logic                            start_edge, timeout_hit, cd_error;
  logic                            buf_clear, err_clear, beat_wr;
  logic                            unused_bits;

  assign unused_bits = ^{i_control_reg[C_S_AXI_DATA_WIDTH-1:9], i_addr_reg[5:0]};

  // cnt_inc is the number of cycles spent waiting, including the current one
  assign start_edge  = i_control_reg[CTRL_START] & ~start_q;
  assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
  assign timeout_hit = (i_timeout_reg != '0) && (cnt_inc == i_timeout_reg);
  assign buf_clear   = (state == ST_IDLE) && start_edge;
  assign err_clear   = (state == ST_IDLE) && i_control_reg[CTRL_CLEAR];
  assign beat_wr     = o_cdready && i_cdvalid;

  ace_cd_line_buffer #(
    .DATA_W (C_ACE_DATA_WIDTH),
    .BEATS  (C_CD_BEATS)
  ) u_line_buf (
    .clk       (ace_aclk),
    .rst_n     (ace_aresetn),
    .clear     (buf_clear),
    .err_clear (err_clear),
    .beat_wr   (beat_wr),
    .beat_last (i_cdlast),
    .beat_data (i_cddata),
    .line_data (o_line_data),
    .cd_error  (cd_error)
  );

  always_comb begin
    o_status_reg                             = '0;
    o_status_reg[STAT_DONE]                  = done_q;
    o_status_reg[STAT_TIMEOUT]               = timeout_q;
    o_status_reg[STAT_PASS_DIRTY]            = pass_dirty_q;
    o_status_reg[STAT_CD_ERROR]              = cd_error;
    o_status_reg[STAT_CRRESP_LSB +: 5]       = crresp_q;
    o_status_reg[STAT_STATE_LSB +: 4]        = state;
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state         <= ST_IDLE;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      pass_dirty_q  <= 1'b0;
      crresp_q      <= '0;
      cnt           <= '0;
      o_latency_reg <= '0;
      o_acvalid     <= 1'b0;
      o_acaddr      <= '0;
      o_acsnoop     <= '0;
      o_acprot      <= '0;
      o_crready     <= 1'b0;
      o_cdready     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      start_q <= i_control_reg[CTRL_START];
      case (state)
        ST_IDLE: begin
          if (i_control_reg[CTRL_CLEAR]) begin
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            pass_dirty_q  <= 1'b0;
            o_latency_reg <= '0;
          end
          if (start_edge) begin
            state         <= ST_AC_REQ;
            o_acvalid     <= 1'b1;
            o_busy        <= 1'b1;
            o_acaddr      <= C_ACE_ADDR_WIDTH'({i_addr_reg[31:6], 6'b0});
            o_acsnoop     <= i_control_reg[CTRL_SNOOP_LSB +: 4];
            o_acprot      <= i_control_reg[CTRL_PROT_LSB +: 3];
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            pass_dirty_q  <= 1'b0;
            crresp_q      <= '0;
            o_latency_reg <= '0;
          end
        end
        ST_AC_REQ: begin
          if (i_acready) begin
            state     <= ST_CR_WAIT;
            o_acvalid <= 1'b0;
            o_crready <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_CR_WAIT: begin
          cnt <= cnt_inc;
          if (i_crvalid) begin
            o_crready     <= 1'b0;
            crresp_q      <= i_crresp;
            pass_dirty_q  <= i_crresp[CRRESP_PASS_DIRTY];
            o_latency_reg <= cnt_inc;
            if (i_crresp[CRRESP_DATA_XFER]) begin
              state     <= ST_CD_RECV;
              o_cdready <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end else if (timeout_hit) begin
            state     <= ST_TIMEOUT;
            o_crready <= 1'b0;
          end
        end
        ST_CD_RECV: begin
          cnt <= cnt_inc;
          if (i_cdvalid && i_cdlast) begin
            state     <= ST_DONE;
            o_cdready <= 1'b0;
          end else if (timeout_hit) begin
            state     <= ST_TIMEOUT;
            o_cdready <= 1'b0;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_TIMEOUT: begin
          done_q    <= 1'b1;
          timeout_q <= 1'b1;
          o_busy    <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          o_acvalid <= 1'b0;
          o_crready <= 1'b0;
          o_cdready <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Bench for ace_snoop_initiator: directed snoops plus randomized responder
// behaviour, checked against a cycle-schedule model of each snoop.
module tb_ace_snoop_initiator;
  import ace_snoop_pkg::*;

  localparam int DW    = 128;
  localparam int BEATS = 4;
  localparam int AW    = 44;

  logic              ace_aclk = 1'b0;
  logic              ace_aresetn = 1'b0;
  logic [31:0]       i_control_reg = '0, i_addr_reg = '0, i_timeout_reg = '0;
  logic [31:0]       o_status_reg, o_latency_reg;
  logic [DW*BEATS-1:0] o_line_data;
  logic              o_acvalid, i_acready = 1'b0;
  logic [AW-1:0]     o_acaddr;
  logic [3:0]        o_acsnoop;
  logic [2:0]        o_acprot;
  logic              i_crvalid = 1'b0, o_crready;
  logic [4:0]        i_crresp = '0;
  logic              i_cdvalid = 1'b0, i_cdlast = 1'b0, o_cdready, o_busy;
  logic [DW-1:0]     i_cddata = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] beat_q [8];
  logic [3:0] snoop_tab [6] = '{ACSNOOP_READ_ONCE, ACSNOOP_READ_SHARED, ACSNOOP_READ_CLEAN,
                                ACSNOOP_READ_UNIQUE, ACSNOOP_CLEAN_INVALID, ACSNOOP_MAKE_INVALID};

  always #5 ace_aclk = ~ace_aclk;

  ace_snoop_initiator dut (
    .ace_aclk      (ace_aclk),
    .ace_aresetn   (ace_aresetn),
    .i_control_reg (i_control_reg),
    .i_addr_reg    (i_addr_reg),
    .i_timeout_reg (i_timeout_reg),
    .o_status_reg  (o_status_reg),
    .o_latency_reg (o_latency_reg),
    .o_line_data   (o_line_data),
    .o_acvalid     (o_acvalid),
    .i_acready     (i_acready),
    .o_acaddr      (o_acaddr),
    .o_acsnoop     (o_acsnoop),
    .o_acprot      (o_acprot),
    .i_crvalid     (i_crvalid),
    .i_crresp      (i_crresp),
    .o_crready     (o_crready),
    .i_cdvalid     (i_cdvalid),
    .i_cddata      (i_cddata),
    .i_cdlast      (i_cdlast),
    .o_cdready     (o_cdready),
    .o_busy        (o_busy)
  );

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // start low for one edge, then high; returns in the first CR_WAIT cycle
  task automatic launch(input logic [31:0] addr, input logic [3:0] snoop, input logic [2:0] prot,
                        input int ac_wait, input bit toggle);
    i_control_reg      = '0;
    i_control_reg[4:1] = snoop;
    i_control_reg[7:5] = prot;
    i_addr_reg         = addr;
    @(negedge ace_aclk);
    i_control_reg[0] = 1'b1;
    @(negedge ace_aclk);
    for (int i = 0; i <= ac_wait; i++) begin
      check_val("ac_ctl", {o_acvalid, o_busy, o_crready, o_cdready}, 4'b1100);
      check_val("ac_addr", o_acaddr, {12'h0, addr[31:6], 6'h0});
      check_val("ac_type", {o_acsnoop, o_acprot}, {snoop, prot});
      if (toggle && i == 2) i_control_reg[0] = 1'b0;
      if (toggle && i == 4) i_control_reg[0] = 1'b1;
      i_acready = (i == ac_wait);
      @(negedge ace_aclk);
    end
    i_acready = 1'b0;
  endtask

  // cycle k counts clock edges since the AC handshake; the model derives
  // where the snoop ends (CR, last beat, or timeout) from that schedule
  task automatic run_snoop(input logic [31:0] addr, input logic [3:0] snoop, input logic [2:0] prot,
                           input int ac_wait, input bit toggle, input int cr_lat, input logic [4:0] resp,
                           input int nbeats, input int tmo, input int max_gap, input bit junk);
    int beat_cyc [8];
    int cyc, k_last, k_end, cr_end, recv;
    bit has_data, tmo_hit, cr_seen;
    logic [511:0] exp_line;
    logic exp_err;
    logic [4:0] exp_resp;
    logic [31:0] exp_lat;

    has_data = resp[0];
    cyc = cr_lat;
    for (int b = 0; b < nbeats; b++) begin
      cyc += 1 + int'($urandom_range(max_gap));
      beat_cyc[b] = cyc;
    end
    k_last  = has_data ? beat_cyc[nbeats-1] : cr_lat;
    tmo_hit = (tmo != 0) && ((tmo < cr_lat) || (has_data && tmo > cr_lat && tmo < k_last));
    k_end   = tmo_hit ? tmo : k_last;
    cr_seen = !(tmo_hit && tmo < cr_lat);
    cr_end  = cr_seen ? cr_lat : k_end;
    recv = 0;
    if (cr_seen && has_data)
      for (int b = 0; b < nbeats; b++)
        if (beat_cyc[b] <= k_end) recv++;
    exp_line = '0;
    for (int b = 0; b < recv && b < BEATS; b++) exp_line[b*DW +: DW] = beat_q[b];
    exp_err  = cr_seen && has_data && (tmo_hit ? (recv > BEATS) : (nbeats != BEATS));
    exp_resp = cr_seen ? resp : 5'b0;
    exp_lat  = cr_seen ? 32'(cr_lat) : 32'd0;

    i_timeout_reg = 32'(tmo);
    launch(addr, snoop, prot, ac_wait, toggle);
    for (int k = 1; k <= k_end; k++) begin
      check_val("rsp_ctl", {o_acvalid, o_crready, o_cdready, o_busy},
                {1'b0, k <= cr_end, cr_seen && has_data && k > cr_lat, 1'b1});
      i_crvalid = cr_seen && (k == cr_lat);
      i_crresp  = i_crvalid ? resp : 5'($urandom);
      i_cdvalid = 1'b0;
      i_cdlast  = 1'b0;
      i_cddata  = '0;
      if (cr_seen && has_data && k > cr_lat) begin
        for (int b = 0; b < nbeats; b++)
          if (beat_cyc[b] == k) begin
            i_cdvalid = 1'b1;
            i_cddata  = beat_q[b];
            i_cdlast  = (b == nbeats - 1);
          end
      end else if (junk) begin
        i_cdvalid = 1'($urandom);
        i_cddata  = {$urandom, $urandom, $urandom, $urandom};
        i_cdlast  = 1'($urandom);
      end
      @(negedge ace_aclk);
    end
    i_crvalid = 1'b0;
    i_cdvalid = 1'b0;
    i_cdlast  = 1'b0;
    check_val("end_ctl", {o_acvalid, o_crready, o_cdready, o_busy}, 4'b0001);
    @(negedge ace_aclk);
    check_val("status", o_status_reg,
              {16'h0, 4'h0, 3'b0, exp_resp, exp_err, exp_resp[2], tmo_hit, 1'b1});
    check_val("latency", o_latency_reg, exp_lat);
    check_val("line", o_line_data, exp_line);
    check_val("idle_ctl", {o_acvalid, o_crready, o_cdready, o_busy}, 4'b0000);
    check_val("ac_hold", {o_acaddr, o_acsnoop, o_acprot}, {12'h0, addr[31:6], 6'h0, snoop, prot});
    if (toggle) begin
      repeat (3) begin
        @(negedge ace_aclk);
        check_val("no_relaunch", {o_acvalid, o_busy}, 2'b00);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge ace_aclk);
    check_val("rst_status", o_status_reg, 32'h0);
    check_val("rst_outs", {o_latency_reg, o_acvalid, o_acaddr, o_acsnoop, o_acprot, o_crready, o_cdready, o_busy}, '0);
    check_val("rst_line", o_line_data, '0);
    ace_aresetn = 1'b1;
    @(negedge ace_aclk);

    run_snoop(32'h1234_5678, ACSNOOP_READ_SHARED, 3'b010, 2, 1'b0, 7, 5'b00000, 0, 0, 0, 1'b0);
    run_snoop(32'h0000_0FC0, ACSNOOP_READ_ONCE, 3'b000, 0, 1'b0, 1, 5'b00000, 0, 0, 0, 1'b0);

    beat_q[0] = {4{32'hAAAA_AAA0}};
    beat_q[1] = {4{32'hBBBB_BBB1}};
    beat_q[2] = {4{32'hCCCC_CCC2}};
    beat_q[3] = {4{32'hDDDD_DDD3}};
    run_snoop(32'h8000_0040, ACSNOOP_READ_UNIQUE, 3'b001, 1, 1'b0, 3, 5'b00001, 4, 0, 0, 1'b1);

    for (int b = 0; b < 8; b++) beat_q[b] = {$urandom, $urandom, $urandom, $urandom};
    run_snoop(32'h4444_4444, ACSNOOP_READ_CLEAN, 3'b100, 0, 1'b0, 2, 5'b00101, 2, 0, 1, 1'b1);

    i_control_reg = 32'h100;
    @(negedge ace_aclk);
    i_control_reg = 32'h0;
    @(negedge ace_aclk);
    check_val("clear_status", o_status_reg, 32'h0000_0050);
    check_val("clear_latency", o_latency_reg, 32'h0);

    run_snoop(32'h1111_2222, ACSNOOP_CLEAN_INVALID, 3'b011, 0, 1'b0, 1000, 5'b00000, 0, 20, 0, 1'b0);
    run_snoop(32'h2222_3333, ACSNOOP_MAKE_INVALID, 3'b111, 10, 1'b1, 4, 5'b00000, 0, 0, 0, 1'b0);
    run_snoop(32'h3333_4444, ACSNOOP_READ_SHARED, 3'b000, 0, 1'b0, 2, 5'b01001, 6, 0, 1, 1'b0);

    for (int b = 0; b < 8; b++) beat_q[b] = {$urandom, $urandom, $urandom, $urandom};
    i_timeout_reg = 32'h0;
    launch(32'hCAFE_F00D, ACSNOOP_READ_UNIQUE, 3'b000, 0, 1'b0);
    i_crvalid = 1'b1;
    i_crresp  = 5'b00001;
    @(negedge ace_aclk);
    i_crvalid = 1'b0;
    i_cdvalid = 1'b1;
    i_cddata  = beat_q[0];
    @(negedge ace_aclk);
    i_cddata  = beat_q[1];
    @(negedge ace_aclk);
    i_cdvalid = 1'b0;
    check_val("mid_cd_ctl", {o_cdready, o_busy}, 2'b11);
    check_val("mid_cd_line", o_line_data, {256'h0, beat_q[1], beat_q[0]});
    #2 ace_aresetn = 1'b0;
    #1;
    check_val("arst_status", o_status_reg, 32'h0);
    check_val("arst_outs", {o_latency_reg, o_acvalid, o_acaddr, o_acsnoop, o_acprot, o_crready, o_cdready, o_busy}, '0);
    check_val("arst_line", o_line_data, '0);
    i_control_reg = '0;
    @(negedge ace_aclk);
    ace_aresetn = 1'b1;
    @(negedge ace_aclk);
    run_snoop(32'hCAFE_F00D, ACSNOOP_READ_UNIQUE, 3'b000, 1, 1'b0, 5, 5'b00001, 4, 0, 1, 1'b0);

    for (int it = 0; it < 30; it++) begin
      int nb, tmo, crl;
      logic [4:0] rsp;
      for (int b = 0; b < 8; b++) beat_q[b] = {$urandom, $urandom, $urandom, $urandom};
      crl = 1 + int'($urandom_range(11));
      rsp = 5'($urandom);
      nb  = ($urandom_range(1) == 0) ? BEATS : 1 + int'($urandom_range(5));
      tmo = ($urandom_range(2) == 0) ? 0 : 1 + int'($urandom_range(24));
      run_snoop($urandom, snoop_tab[$urandom_range(5)], 3'($urandom), int'($urandom_range(3)),
                1'($urandom_range(1)), crl, rsp, nb, tmo, int'($urandom_range(2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
